// File: rtl/bsg_wormhole_router_pkg.sv
// Shared types for the wormhole router output-port controls.
package bsg_wormhole_router_pkg;

    typedef enum logic {
        eIdle,
        eLocked
    } bsg_wormhole_wrr_state_e;

endpackage

// File: rtl/bsg_wormhole_router_rr_pick.sv
// Combinational rotating-priority picker: the first set request bit,
// searching cyclically upward from a start index, wins.
module bsg_wormhole_router_rr_pick #(
    parameter int width_p = 5,
    localparam int idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]      reqs_i,
    input  logic [idx_width_lp-1:0] start_i,
    output logic [width_p-1:0]      grant_o,
    output logic [idx_width_lp-1:0] winner_o,
    output logic                    found_o
);

    // Walk the request vector once starting at start_i, wrapping at width_p.
    always_comb begin
        int cand;
        grant_o  = '0;
        winner_o = '0;
        found_o  = 1'b0;
        cand     = 0;
        for (int i = 0; i < width_p; i++) begin
            cand = int'(start_i) + i;
            if (cand >= width_p) begin
                cand = cand - width_p;
            end
            if (!found_o && reqs_i[cand]) begin
                found_o       = 1'b1;
                winner_o      = idx_width_lp'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_router_output_wrr.sv
// Weighted round-robin output scheduler: picks an input whose head is a
// header for this output, holds it for the whole packet by counting body
// flits, and lets each input send up to its weight in packets per turn.
module bsg_wormhole_router_output_wrr
    import bsg_wormhole_router_pkg::*;
#(
    parameter int input_dirs_p   = 5,
    parameter int len_width_p    = 4,
    parameter int weight_width_p = 3
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [input_dirs_p-1:0]                reqs_i,
    input  logic [input_dirs_p-1:0]                valid_i,
    input  logic [input_dirs_p*len_width_p-1:0]    len_i,
    input  logic [input_dirs_p*weight_width_p-1:0] weights_i,
    input  logic                                   ready_i,
    output logic                                   valid_o,
    output logic [input_dirs_p-1:0]                data_sel_o,
    output logic [input_dirs_p-1:0]                yumi_o,
    output logic                                   busy_o
);

    localparam int ptr_width_lp = (input_dirs_p > 1) ? $clog2(input_dirs_p) : 1;

    bsg_wormhole_wrr_state_e state_r, state_n;
    logic [ptr_width_lp-1:0]   owner_r, owner_n;
    logic [ptr_width_lp-1:0]   ptr_r, ptr_n;
    logic [len_width_p-1:0]    cnt_r, cnt_n;
    logic [weight_width_p-1:0] credit_r, credit_n;

    logic [len_width_p-1:0]    len_arr    [input_dirs_p];
    logic [weight_width_p-1:0] weight_arr [input_dirs_p];

    logic [input_dirs_p-1:0]   pick_grant;
    logic [ptr_width_lp-1:0]   pick_idx;
    logic                      pick_found;

    logic [input_dirs_p-1:0]   owner_onehot;
    logic [input_dirs_p-1:0]   sel;
    logic                      transfer;
    logic                      new_turn;
    logic [weight_width_p-1:0] weight_eff;
    logic [weight_width_p-1:0] turn_credit;

    function automatic logic [ptr_width_lp-1:0] next_idx(input logic [ptr_width_lp-1:0] idx);
        return (idx == ptr_width_lp'(input_dirs_p - 1)) ? '0 : idx + ptr_width_lp'(1);
    endfunction

    for (genvar k = 0; k < input_dirs_p; k++) begin : g_unpack
        assign len_arr[k]    = len_i[k*len_width_p +: len_width_p];
        assign weight_arr[k] = weights_i[k*weight_width_p +: weight_width_p];
    end

    bsg_wormhole_router_rr_pick #(
        .width_p (input_dirs_p)
    ) pick (
        .reqs_i   (reqs_i),
        .start_i  (ptr_r),
        .grant_o  (pick_grant),
        .winner_o (pick_idx),
        .found_o  (pick_found)
    );

    assign owner_onehot = input_dirs_p'(1) << owner_r;

    // Grant source: the held owner while locked, otherwise this cycle's pick.
    always_comb begin
        sel = '0;
        if (!reset_i) begin
            if (state_r == eLocked) begin
                sel = owner_onehot;
            end else if (pick_found) begin
                sel = pick_grant;
            end
        end
    end

    assign data_sel_o = sel;
    assign valid_o    = |(sel & valid_i);
    assign transfer   = valid_o & ready_i;
    assign yumi_o     = transfer ? sel : '0;
    assign busy_o     = (state_r == eLocked) && !reset_i;

    assign new_turn    = (pick_idx != owner_r) || (credit_r == '0);
    assign weight_eff  = (weight_arr[pick_idx] == '0) ? weight_width_p'(1) : weight_arr[pick_idx];
    assign turn_credit = new_turn ? weight_eff : credit_r;

    // Next-state: turn bookkeeping on header pick, flit counting while locked.
    always_comb begin
        state_n  = state_r;
        owner_n  = owner_r;
        ptr_n    = ptr_r;
        cnt_n    = cnt_r;
        credit_n = credit_r;
        case (state_r)
            eIdle: begin
                if (pick_found) begin
                    owner_n  = pick_idx;
                    credit_n = turn_credit;
                    if (new_turn) begin
                        ptr_n = pick_idx;
                    end
                    if (transfer) begin
                        if (len_arr[pick_idx] == '0) begin
                            credit_n = turn_credit - weight_width_p'(1);
                            ptr_n    = (turn_credit == weight_width_p'(1)) ? next_idx(pick_idx) : pick_idx;
                        end else begin
                            cnt_n   = len_arr[pick_idx];
                            state_n = eLocked;
                        end
                    end
                end
            end
            eLocked: begin
                if (transfer) begin
                    cnt_n = cnt_r - len_width_p'(1);
                    if (cnt_r == len_width_p'(1)) begin
                        state_n  = eIdle;
                        credit_n = credit_r - weight_width_p'(1);
                        ptr_n    = (credit_r == weight_width_p'(1)) ? next_idx(owner_r) : owner_r;
                    end
                end
            end
            default: state_n = eIdle;
        endcase
    end

    // Scheduler state registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= eIdle;
            owner_r  <= '0;
            ptr_r    <= '0;
            cnt_r    <= '0;
            credit_r <= '0;
        end else begin
            state_r  <= state_n;
            owner_r  <= owner_n;
            ptr_r    <= ptr_n;
            cnt_r    <= cnt_n;
            credit_r <= credit_n;
        end
    end

`ifndef SYNTHESIS
    a_sel_onehot0 : assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(data_sel_o));
    a_yumi_valid  : assert property (@(posedge clk_i) disable iff (reset_i) (yumi_o & ~valid_i) == '0);
    a_locked_hold : assert property (@(posedge clk_i) disable iff (reset_i)
                                     (state_r == eLocked) |-> (data_sel_o == owner_onehot));
`endif

endmodule

// File: tb/tb_bsg_wormhole_router_output_wrr.sv
// Directed bench for the weighted round-robin output scheduler.
module tb_bsg_wormhole_router_output_wrr;

    localparam int dirs_lp = 5;
    localparam int lenw_lp = 4;
    localparam int wtw_lp  = 3;

    logic                        clk_i = 1'b0;
    logic                        reset_i;
    logic [dirs_lp-1:0]          reqs_i;
    logic [dirs_lp-1:0]          valid_i;
    logic [dirs_lp*lenw_lp-1:0]  len_i;
    logic [dirs_lp*wtw_lp-1:0]   weights_i;
    logic                        ready_i;
    logic                        valid_o;
    logic [dirs_lp-1:0]          data_sel_o;
    logic [dirs_lp-1:0]          yumi_o;
    logic                        busy_o;

    int checks   = 0;
    int failures = 0;

    bsg_wormhole_router_output_wrr #(
        .input_dirs_p   (dirs_lp),
        .len_width_p    (lenw_lp),
        .weight_width_p (wtw_lp)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .reqs_i     (reqs_i),
        .valid_i    (valid_i),
        .len_i      (len_i),
        .weights_i  (weights_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .data_sel_o (data_sel_o),
        .yumi_o     (yumi_o),
        .busy_o     (busy_o)
    );

    // 10-time-unit clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [dirs_lp-1:0] r, input logic [dirs_lp-1:0] v, input logic rdy);
        reqs_i  = r;
        valid_i = v;
        ready_i = rdy;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [dirs_lp-1:0] sel, input logic vo,
                              input logic [dirs_lp-1:0] yumi, input logic busy);
        checkOutput({tag, ".sel"},   32'(data_sel_o), 32'(sel));
        checkOutput({tag, ".valid"}, 32'(valid_o),    32'(vo));
        checkOutput({tag, ".yumi"},  32'(yumi_o),     32'(yumi));
        checkOutput({tag, ".busy"},  32'(busy_o),     32'(busy));
        @(negedge clk_i);
    endtask

    task automatic setLen(input int k, input logic [lenw_lp-1:0] v);
        len_i[k*lenw_lp +: lenw_lp] = v;
    endtask

    task automatic setWeight(input int k, input logic [wtw_lp-1:0] v);
        weights_i[k*wtw_lp +: wtw_lp] = v;
    endtask

    task automatic doReset();
        reset_i   = 1'b1;
        reqs_i    = '0;
        valid_i   = '0;
        ready_i   = 1'b0;
        len_i     = '0;
        weights_i = {dirs_lp{3'd1}};
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, each starting from a fresh reset.
    initial begin
        logic [dirs_lp-1:0] seq2 [4];
        logic [dirs_lp-1:0] seq3 [10];
        seq2 = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};
        seq3 = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010,
                 5'b00010, 5'b10000, 5'b10000, 5'b00010, 5'b00010};

        // Outputs forced low during reset even with an active request.
        reset_i   = 1'b1;
        len_i     = '0;
        weights_i = {dirs_lp{3'd1}};
        applyStimulus(5'b00001, 5'b11111, 1'b1);
        checkOutput("rst.sel",   32'(data_sel_o), 32'(0));
        checkOutput("rst.valid", 32'(valid_o),    32'(0));
        checkOutput("rst.yumi",  32'(yumi_o),     32'(0));
        checkOutput("rst.busy",  32'(busy_o),     32'(0));
        @(negedge clk_i);
        doReset();

        // Single requester on input 2, len=3, then probe pointer progression.
        $display("[TB] single requester");
        setLen(2, 4'd3);
        applyStimulus(5'b00100, 5'b11111, 1'b1);
        checkCycle("t1.hdr", 5'b00100, 1'b1, 5'b00100, 1'b0);
        applyStimulus(5'b00000, 5'b11111, 1'b1);
        checkCycle("t1.b1", 5'b00100, 1'b1, 5'b00100, 1'b1);
        checkCycle("t1.b2", 5'b00100, 1'b1, 5'b00100, 1'b1);
        checkCycle("t1.b3", 5'b00100, 1'b1, 5'b00100, 1'b1);
        len_i = '0;
        applyStimulus(5'b10101, 5'b11111, 1'b1);
        checkCycle("t1.ptr3", 5'b10000, 1'b1, 5'b10000, 1'b0);
        checkCycle("t1.wrap", 5'b00001, 1'b1, 5'b00001, 1'b0);
        checkCycle("t1.ptr1", 5'b00100, 1'b1, 5'b00100, 1'b0);
        checkCycle("t1.ptr3b", 5'b10000, 1'b1, 5'b10000, 1'b0);

        // Idle with no requests, then inputs 0 and 3 alternating single-flit packets.
        doReset();
        $display("[TB] alternating single-flit");
        applyStimulus(5'b00000, 5'b11111, 1'b1);
        checkCycle("t2.noreq", 5'b00000, 1'b0, 5'b00000, 1'b0);
        applyStimulus(5'b01001, 5'b11111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkCycle($sformatf("t2.c%0d", i), seq2[i], 1'b1, seq2[i], 1'b0);
        end

        // Weight 3 on input 1 against weight 1 on input 4, len=1 packets.
        doReset();
        $display("[TB] weighted turns");
        setWeight(1, 3'd3);
        setWeight(4, 3'd1);
        setLen(1, 4'd1);
        setLen(4, 4'd1);
        applyStimulus(5'b10010, 5'b11111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkCycle($sformatf("t3.c%0d", i), seq3[i], 1'b1, seq3[i], 1'((i % 2) == 1));
        end

        // Locked on input 0 with stalls; input 2 waits for the fifth flit.
        doReset();
        $display("[TB] locked with stalls");
        setLen(0, 4'd4);
        applyStimulus(5'b00101, 5'b11111, 1'b1);
        checkCycle("t4.hdr", 5'b00001, 1'b1, 5'b00001, 1'b0);
        checkCycle("t4.b1", 5'b00001, 1'b1, 5'b00001, 1'b1);
        applyStimulus(5'b00101, 5'b11111, 1'b0);
        checkCycle("t4.rdy0a", 5'b00001, 1'b1, 5'b00000, 1'b1);
        checkCycle("t4.rdy0b", 5'b00001, 1'b1, 5'b00000, 1'b1);
        applyStimulus(5'b00101, 5'b11110, 1'b1);
        checkCycle("t4.vstall", 5'b00001, 1'b0, 5'b00000, 1'b1);
        applyStimulus(5'b00101, 5'b11111, 1'b1);
        checkCycle("t4.b2", 5'b00001, 1'b1, 5'b00001, 1'b1);
        checkCycle("t4.b3", 5'b00001, 1'b1, 5'b00001, 1'b1);
        checkCycle("t4.b4", 5'b00001, 1'b1, 5'b00001, 1'b1);
        checkCycle("t4.next", 5'b00100, 1'b1, 5'b00100, 1'b0);

        // Input 0 leaves credit unused; input 1 takes a fresh turn of weight 2.
        doReset();
        $display("[TB] credit fall-through");
        setWeight(0, 3'd3);
        setWeight(1, 3'd2);
        applyStimulus(5'b00001, 5'b11111, 1'b1);
        checkCycle("t5.in0", 5'b00001, 1'b1, 5'b00001, 1'b0);
        applyStimulus(5'b00010, 5'b11111, 1'b1);
        checkCycle("t5.in1a", 5'b00010, 1'b1, 5'b00010, 1'b0);
        applyStimulus(5'b00011, 5'b11111, 1'b1);
        checkCycle("t5.in1b", 5'b00010, 1'b1, 5'b00010, 1'b0);
        checkCycle("t5.rot", 5'b00001, 1'b1, 5'b00001, 1'b0);

        // Reset mid-packet, then search restarts from input 0; weight 0 acts as 1.
        doReset();
        $display("[TB] reset while locked");
        setWeight(3, 3'd0);
        setLen(4, 4'd3);
        applyStimulus(5'b10000, 5'b11111, 1'b1);
        checkCycle("t6.hdr", 5'b10000, 1'b1, 5'b10000, 1'b0);
        checkCycle("t6.b1", 5'b10000, 1'b1, 5'b10000, 1'b1);
        reset_i = 1'b1;
        applyStimulus(5'b11000, 5'b11111, 1'b1);
        checkOutput("t6.rst.sel",   32'(data_sel_o), 32'(0));
        checkOutput("t6.rst.valid", 32'(valid_o),    32'(0));
        checkOutput("t6.rst.yumi",  32'(yumi_o),     32'(0));
        checkOutput("t6.rst.busy",  32'(busy_o),     32'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        len_i   = '0;
        applyStimulus(5'b11000, 5'b11111, 1'b1);
        checkCycle("t6.in3", 5'b01000, 1'b1, 5'b01000, 1'b0);
        checkCycle("t6.in4", 5'b10000, 1'b1, 5'b10000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_router_output_wrr.md
# bsg_wormhole_router_output_wrr

Weighted round-robin output-port scheduler for the wormhole router. One instance per output direction. It arbitrates among sparse input channels whose FIFO head is a header routed to this output, then holds the grant for the whole packet by counting flits itself from the header length field. A per-input weight lets an input send several consecutive packets before priority rotates to the next input.

## Interface
Parameters:
- input_dirs_p, 5: number of sparse input channels that can reach this output.
- len_width_p, 4: width of the header `len` field, which gives the number of body flits after the header.
- weight_width_p, 3: width of each per-input weight.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. Asynchronous, active-high.
- reqs_i  in  input_dirs_p  bit k = input k's FIFO head is a header destined to this output. Ignored while LOCKED.
- valid_i  in  input_dirs_p  input FIFO head valid.
- len_i  in  input_dirs_p*len_width_p  `len` field of each FIFO head. Meaningful only with reqs_i[k].
- weights_i  in  input_dirs_p*weight_width_p  packets per turn for each input; 0 is treated as 1. Quasi-static.
- ready_i  in  1  downstream ready_and.
- valid_o  out  1  flit presented downstream.
- data_sel_o  out  input_dirs_p  one-hot select for the data mux. All zeros when no owner.
- yumi_o  out  input_dirs_p  dequeue strobe to input k, equal to data_sel_o[k] & valid_o & ready_i.
- busy_o  out  1  state is LOCKED.

## Operation
- State registers:
  - state: IDLE or LOCKED.
  - owner_r: index of the input being served.
  - cnt_r: len_width_p bits, body flits remaining.
  - ptr_r: round-robin start index.
  - credit_r: weight_width_p bits, packets left in the current turn.
- IDLE:
  - The winner is the first set bit of reqs_i, searching cyclically from ptr_r. The winner's data_sel_o bit is asserted.
  - valid_o = valid_i[winner].
  - A transfer is valid_o & ready_i.
  - If winner != owner_r, or credit_r == 0, a new turn starts: credit_r loads max(weights_i[winner],1), owner_r loads winner, ptr_r loads winner. A continuing turn changes none of these.
  - On header transfer with len_i[winner] == 0, the packet ends immediately (see packet end) and state stays IDLE.
  - On header transfer with len_i[winner] != 0: cnt_r loads len_i[winner] and state goes to LOCKED.
- LOCKED:
  - data_sel_o = onehot(owner_r).
  - valid_o = valid_i[owner_r].
  - reqs_i is ignored.
  - Each transfer decrements cnt_r.
  - A transfer with cnt_r == 1 is packet end; state goes to IDLE.
- Packet end: credit_r decrements by 1 (this uses the freshly loaded value if the turn started this cycle). If the result is 0, ptr_r becomes (owner_r+1) mod input_dirs_p. Otherwise ptr_r stays on owner_r.
- Owner has credit left but no pending header: the next IDLE pick searches from ptr_r = owner_r and falls through to the next requester, which starts a new turn.
- Boundary conditions:
  - If no reqs_i bit is set in IDLE, valid_o = 0 and no register changes.
  - A valid_i de-assertion mid-packet stalls the grant; it is never released early.
  - ptr_r wraps from input_dirs_p-1 to 0.
  - weights_i is sampled only at turn start.
- While reset_i is asserted, valid_o, yumi_o, data_sel_o and busy_o are 0, regardless of inputs.
- Reset values: state=IDLE, owner_r=0, cnt_r=0, ptr_r=0, credit_r=0.

## Timing
- Arbitration is zero-cycle: the grant, valid_o and yumi_o are combinational from reqs_i, valid_i and ready_i in the same cycle as the header. The flit passes through with no added latency.
- State updates on the rising edge of clk_i after a transfer.
- There is no bubble between packets. A packet of N body flits occupies exactly N+1 transfer cycles when valid_i and ready_i are held high. Single-flit packets sustain 1 per cycle.
- Deasserting reset mid-packet returns to IDLE with credit_r=0. Upstream FIFOs are reset by the same reset_i.
- Assertions, outside synthesis:
  - data_sel_o is one-hot or zero.
  - No yumi_o without valid_i.
  - reqs_i bits are ignored in LOCKED.

## Structure
- The shared package bsg_wormhole_router_pkg receives the state enum bsg_wormhole_wrr_state_e {eIdle, eLocked}. No other constants go there.
- Sub-module bsg_wormhole_router_rr_pick: a combinational rotating-priority picker. Inputs are a request vector and a start pointer; outputs are a one-hot grant, the winner index and a found flag. It is reusable by other output controls.
- The FSM, counters and credit logic stay in the top module, in 120–250 lines total.

## Test plan
- Single requester, 5 inputs, input 2, len=3, weights=1, ready high → 4 consecutive yumi_o[2] pulses and busy_o high for 3 cycles. ptr_r then becomes 3.
- Inputs 0 and 3 requesting continuously with len=0 and all weights=1 → grants alternate 0,3,0,3 every cycle.
- weights_i[1]=3, weights_i[4]=1, inputs 1 and 4 continuously sending len=1 packets → grant sequence 1,1,1,4,1,1,1,4 at packet granularity, with no bubbles.
- LOCKED on input 0 with len=4 while input 2 requests, and ready_i low for 2 cycles mid-packet → input 2 is not granted until input 0's 5th flit transfers. Input 2 is granted on the next cycle.
- Input 0 has credit 2 left but stops requesting after one packet, and input 1 requests → input 1 is granted immediately. credit_r reloads to weights_i[1].
- reset_i asserted while LOCKED with cnt_r=2 → all outputs go to 0 immediately. After release, a new header from input 3 is granted from ptr_r=0 search order.
